fifo_burst_reader: RTL
======================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 16, giving the payload word width; legal values are 16 or more.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have the port rd_data, input, DATA_WIDTH bits: FIFO head word, first-word-fall-through, valid whenever rd_empty=0.
REQ-005 The block SHALL have the port rd_empty, input, 1 bit: the hierarchical FIFO is empty.
REQ-006 The block SHALL have the port rd_en, output, 1 bit: pop strobe; the head word is consumed at the rising edge where rd_en=1.
REQ-007 The block SHALL have the port enable, input, 1 bit: allows new packets to start.
REQ-008 The block SHALL have the port burst_len, input, 8 bits: payload words per packet; the value 0 SHALL be treated as 1.
REQ-009 The block SHALL have the port timeout_cycles, input, 8 bits: empty-stall limit; the value 0 disables the timeout.
REQ-010 The block SHALL have the port m_data, output, DATA_WIDTH bits: downstream stream data.
REQ-011 The block SHALL have the port m_valid, output, 1 bit: downstream stream valid.
REQ-012 The block SHALL have the port m_ready, input, 1 bit: downstream stream ready.
REQ-013 The block SHALL have the port m_last, output, 1 bit: marks the final word of a packet (the trailer).
REQ-014 The block SHALL have the port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 The block SHALL have the port pkt_count, output, 16 bits: number of completed packets, wrapping.
REQ-016 The block SHALL have the port timeout_flush, output, 1 bit: one-cycle pulse when a packet is closed by timeout.

Function
REQ-017 The state machine SHALL have the states IDLE, PAYLOAD, CSUM (present only with the Configuration macro) and TRAILER.
REQ-018 IDLE SHALL go to PAYLOAD when enable=1 and rd_empty=0; the word count, stall counter and checksum SHALL be cleared on entry.
REQ-019 rd_en SHALL be combinational and equal to (state==PAYLOAD and rd_empty=0 and word count < effective burst_len and (m_valid=0 or m_ready=1)).
REQ-020 A word popped at edge N SHALL be registered and presented with m_valid=1 and m_last=0 from edge N onward, so latency is 1 cycle.
REQ-021 m_valid/m_data/m_last SHALL hold stable until an edge with m_valid=1 and m_ready=1; a new word may replace the old one at that same edge.
REQ-022 PAYLOAD SHALL exit to CSUM/TRAILER at the edge where the pop bringing the word count to the effective burst_len occurs.
REQ-023 Stall counter behaviour in PAYLOAD:
- it increments each cycle where word count >= 1 and rd_empty=1;
- it clears on every pop;
- when it equals a nonzero timeout_cycles, the state SHALL go to CSUM/TRAILER and timeout_flush SHALL pulse for 1 cycle.
REQ-024 The timeout SHALL never fire while word count = 0.
REQ-025 The state SHALL stay in PAYLOAD waiting for the first word.
REQ-026 TRAILER SHALL load m_data = {seq[7:0], count[7:0]}, zero-extended to DATA_WIDTH, with m_last=1, once the output register is free.
REQ-027 In REQ-026, count is the number of payload words popped (1..255) and seq is the packet index, starting at 0 after reset and wrapping at 255.
REQ-028 When the trailer handshake completes, the block SHALL increment pkt_count and seq and return to IDLE.
REQ-029 The block SHALL start a new packet at the earliest in the cycle following the trailer handshake.
REQ-030 Deasserting enable mid-packet SHALL NOT truncate the packet; the block finishes the packet, then waits in IDLE.
REQ-031 burst_len and timeout_cycles SHALL be sampled on IDLE->PAYLOAD and held for the whole packet.
REQ-032 With m_ready held at 0, the block SHALL pop no further words once the output register is full; no data is lost or duplicated.

Reset
REQ-033 While rst_n=0, the block SHALL immediately set:
- state = IDLE;
- m_valid = 0, m_last = 0, m_data = 0;
- busy = 0, timeout_flush = 0;
- pkt_count = 0, seq = 0, and all counters = 0.
REQ-034 rd_en SHALL be 0 during reset.
REQ-035 A reset mid-packet SHALL abort the packet without emitting a trailer; words already popped are discarded.

Configuration
REQ-036 When the macro FIFO_READER_CHECKSUM_EN is defined, CSUM SHALL emit one word, m_last=0, holding the XOR of all payload words of the packet, between the last payload word and the trailer.
REQ-037 When FIFO_READER_CHECKSUM_EN is undefined, CSUM and the checksum register SHALL be absent, and PAYLOAD SHALL go directly to TRAILER.

Verification
REQ-038 The bench SHALL cover: preload 20 words 0x0000..0x0013, burst_len=8, m_ready=1 -> packets of 8, 8 and 4 words (the last closed by timeout_cycles=10), trailers 0x0008, 0x0108, 0x0204, and timeout_flush pulses once.
REQ-039 The bench SHALL cover: burst_len=4 with m_ready toggling 1010... -> stream 0x0100..0x0103 in order, stable while stalled, with no word lost or duplicated.
REQ-040 The bench SHALL cover: timeout_cycles=0, 3 words preloaded, burst_len=8 -> no trailer until 5 more words arrive, then trailer 0x0008.
REQ-041 The bench SHALL cover: with FIFO_READER_CHECKSUM_EN defined, payload 0x00F0, 0x000F -> checksum word 0x00FF precedes trailer 0x0002.
REQ-042 The bench SHALL cover: assert rst_n=0 after 3 of 8 payload words -> m_valid=0, pkt_count=0 and busy=0 at once; after release, the next trailer seq = 0.
REQ-043 The bench SHALL cover: enable dropped after the 2nd of 4 words -> packet completes with trailer 0x0004, and busy=0 afterwards with the FIFO non-empty.

Source files
------------

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port and downstream stream bundle for fifo_burst_reader.
// master = the reader block, slave = FIFO/sink side.
interface fifo_burst_reader_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_empty;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
        input  rd_data, rd_empty, m_ready,
        output rd_en, m_data, m_valid, m_last
    );

    modport slave (
        output rd_data, rd_empty, m_ready,
        input  rd_en, m_data, m_valid, m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops bursts from a FWFT FIFO into packets closed by a {seq,count} trailer word.
// Define FIFO_READER_CHECKSUM_EN to insert an XOR checksum word before the trailer.
module fifo_burst_reader #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fifo_burst_reader_if.master        bus,
    input  logic                       enable,
    input  logic [7:0]                 burst_len,
    input  logic [7:0]                 timeout_cycles,
    output logic                       busy,
    output logic [15:0]                pkt_count,
    output logic                       timeout_flush
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned PKT_W = 16;

`ifdef FIFO_READER_CHECKSUM_EN
    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_CSUM, ST_TRAILER} state_t;
    localparam state_t ST_AFTER_PAYLOAD = ST_CSUM;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_TRAILER} state_t;
    localparam state_t ST_AFTER_PAYLOAD = ST_TRAILER;
`endif

    state_t                r_state;
    logic [CNT_W-1:0]      r_word_cnt;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_burst_len;
    logic [CNT_W-1:0]      r_timeout;
    logic [CNT_W-1:0]      r_seq;
    logic [PKT_W-1:0]      r_pkt_count;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic                  r_busy;
    logic                  r_timeout_flush;
`ifdef FIFO_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_csum;
`endif

    logic w_out_free;
    logic w_rd_en;
    logic w_last_pop;
    logic w_timeout_hit;

    // Output register can take a new word when empty or draining this edge.
    assign w_out_free    = !r_m_valid || bus.m_ready;
    assign w_rd_en       = (r_state == ST_PAYLOAD) && !bus.rd_empty &&
                           (r_word_cnt < r_burst_len) && w_out_free;
    assign w_last_pop    = w_rd_en && ((r_word_cnt + CNT_W'(1)) == r_burst_len);
    assign w_timeout_hit = (r_state == ST_PAYLOAD) && !w_rd_en &&
                           (r_timeout != '0) && (r_stall_cnt == r_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_word_cnt      <= '0;
            r_stall_cnt     <= '0;
            r_burst_len     <= '0;
            r_timeout       <= '0;
            r_seq           <= '0;
            r_pkt_count     <= '0;
            r_m_data        <= '0;
            r_m_valid       <= 1'b0;
            r_m_last        <= 1'b0;
            r_busy          <= 1'b0;
            r_timeout_flush <= 1'b0;
`ifdef FIFO_READER_CHECKSUM_EN
            r_csum          <= '0;
`endif
        end else begin
            r_timeout_flush <= 1'b0;
            if (r_m_valid && bus.m_ready) begin
                r_m_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (enable && !bus.rd_empty) begin
                        r_state     <= ST_PAYLOAD;
                        r_busy      <= 1'b1;
                        r_word_cnt  <= '0;
                        r_stall_cnt <= '0;
                        r_burst_len <= (burst_len == '0) ? CNT_W'(1) : burst_len;
                        r_timeout   <= timeout_cycles;
`ifdef FIFO_READER_CHECKSUM_EN
                        r_csum      <= '0;
`endif
                    end
                end

                // A pop always wins over the stall timeout in the same cycle.
                ST_PAYLOAD: begin
                    if (w_rd_en) begin
                        r_m_data    <= bus.rd_data;
                        r_m_valid   <= 1'b1;
                        r_m_last    <= 1'b0;
                        r_word_cnt  <= r_word_cnt + CNT_W'(1);
                        r_stall_cnt <= '0;
`ifdef FIFO_READER_CHECKSUM_EN
                        r_csum      <= r_csum ^ bus.rd_data;
`endif
                        if (w_last_pop) begin
                            r_state <= ST_AFTER_PAYLOAD;
                        end
                    end else if (w_timeout_hit) begin
                        r_state         <= ST_AFTER_PAYLOAD;
                        r_timeout_flush <= 1'b1;
                    end else if ((r_word_cnt != '0) && bus.rd_empty) begin
                        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                    end
                end

`ifdef FIFO_READER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_out_free) begin
                        r_m_data  <= r_csum;
                        r_m_valid <= 1'b1;
                        r_m_last  <= 1'b0;
                        r_state   <= ST_TRAILER;
                    end
                end
`endif

                // m_last only ever marks the trailer, so valid&last means it is loaded.
                ST_TRAILER: begin
                    if (r_m_valid && r_m_last) begin
                        if (bus.m_ready) begin
                            r_m_last    <= 1'b0;
                            r_pkt_count <= r_pkt_count + PKT_W'(1);
                            r_seq       <= r_seq + CNT_W'(1);
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end else if (w_out_free) begin
                        r_m_data  <= DATA_WIDTH'({r_seq, r_word_cnt});
                        r_m_valid <= 1'b1;
                        r_m_last  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_en     = w_rd_en;
    assign bus.m_data    = r_m_data;
    assign bus.m_valid   = r_m_valid;
    assign bus.m_last    = r_m_last;
    assign busy          = r_busy;
    assign pkt_count     = r_pkt_count;
    assign timeout_flush = r_timeout_flush;
endmodule
